npc_exec_seq: RTL and testbench



---
 rtl/npc_seq_pkg.sv | 14 +
 rtl/npc_seq_perf.sv | 25 ++
 rtl/npc_exec_seq.sv | 87 ++++++++
 tb/tb_npc_exec_seq.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/npc_seq_pkg.sv
// npc_seq_pkg: shared state encoding and sizing for the NPC execution sequencer.
package npc_seq_pkg;
  localparam int STATE_W = 7;
  localparam int DEFAULT_CNT_W = 64;
  typedef enum logic [STATE_W-1:0] {
    S_BOOT   = 7'b0000001,
    S_FETCH  = 7'b0000010,
    S_DECODE = 7'b0000100,
    S_EXEC   = 7'b0001000,
    S_MEM    = 7'b0010000,
    S_WB     = 7'b0100000,
    S_HALT   = 7'b1000000
  } seq_state_t;
endpackage

// File: rtl/npc_seq_perf.sv
// npc_seq_perf: free-running cycle counter and retired-instruction counter.
module npc_seq_perf
  import npc_seq_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             commit,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  logic [CNT_W-1:0] r_cycle, r_instret;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      r_cycle   <= r_cycle + 1'b1;
      r_instret <= r_instret + CNT_W'(commit);
    end
  end
  assign cycle_cnt   = r_cycle;
  assign instret_cnt = r_instret;
endmodule

// File: rtl/npc_exec_seq.sv
// npc_exec_seq: multi-cycle fetch/decode/exec/mem/wb sequencer for the NPC datapath.
// Define NPC_SEQ_PERF_EN to build the cycle/instret counters; otherwise they read 0.
module npc_exec_seq
  import npc_seq_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req,
  input  logic             ifu_ack,
  input  logic             ifu_err,
  output logic             ir_we,
  input  logic             dec_rd_wr,
  input  logic             dec_is_load,
  input  logic             dec_is_store,
  input  logic             dec_is_ebreak,
  input  logic             exe_redirect,
  output logic             lsu_req,
  output logic             lsu_we,
  input  logic             lsu_ack,
  input  logic             lsu_err,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             commit,
  output logic             halt,
  output logic             halt_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);
  seq_state_t r_state, w_next;
  logic r_rd_wr, r_is_store, r_pc_sel, r_halt_err;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT:   w_next = S_FETCH;
      S_FETCH:  w_next = !ifu_ack ? S_FETCH : ifu_err ? S_HALT : S_DECODE;
      S_DECODE: w_next = dec_is_ebreak ? S_HALT : S_EXEC;
      S_EXEC:   w_next = (dec_is_load | dec_is_store) ? S_MEM : S_WB;
      S_MEM:    w_next = !lsu_ack ? S_MEM : lsu_err ? S_HALT : S_WB;
      S_WB:     w_next = S_FETCH;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_BOOT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_BOOT;
      r_rd_wr    <= 1'b0;
      r_is_store <= 1'b0;
      r_pc_sel   <= 1'b0;
      r_halt_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXEC) begin
        r_rd_wr    <= dec_rd_wr;
        r_is_store <= dec_is_store;
        r_pc_sel   <= exe_redirect;
      end
      // only ebreak halts from DECODE; every other way into HALT is an access fault
      if (w_next == S_HALT && r_state != S_HALT) r_halt_err <= r_state != S_DECODE;
    end
  end
  assign ifu_req  = r_state == S_FETCH;
  assign ir_we    = ifu_req & ifu_ack & ~ifu_err;
  assign lsu_req  = r_state == S_MEM;
  assign lsu_we   = lsu_req & r_is_store;
  assign pc_we    = r_state == S_WB;
  assign rf_we    = pc_we & r_rd_wr;
  assign pc_sel   = pc_we & r_pc_sel;
  assign commit   = pc_we;
  assign halt     = r_state == S_HALT;
  assign halt_err = r_halt_err;
`ifdef NPC_SEQ_PERF_EN
  npc_seq_perf #(.CNT_W(CNT_W)) u_perf (
    .clk        (clk),
    .rst_n      (rst_n),
    .commit     (commit),
    .cycle_cnt  (cycle_cnt),
    .instret_cnt(instret_cnt)
  );
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif
endmodule

// File: tb/tb_npc_exec_seq.sv
// tb_npc_exec_seq: randomized instruction stream with a scoreboard of expected commits/halts.
module tb_npc_exec_seq;
  logic clk = 0, rst_n = 0;
  logic ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_we, pc_sel, commit, halt, halt_err;
  logic ifu_ack = 0, ifu_err = 0, lsu_ack = 0, lsu_err = 0;
  logic dec_rd_wr = 0, dec_is_load = 0, dec_is_store = 0, dec_is_ebreak = 0, exe_redirect = 0;
  logic [63:0] cycle_cnt, instret_cnt;
  int checks = 0, errors = 0;
  typedef struct {
    bit is_halt;
    bit rf_we;
    bit pc_sel;
    bit herr;
    int lat;
    longint unsigned ret;
  } exp_t;
  exp_t exp_q[$];
  longint unsigned tb_cyc = 0, n_commit = 0, f_start = 0;
  logic prev_req = 0, prev_halt = 0;

  npc_exec_seq dut (
    .clk(clk), .rst_n(rst_n), .ifu_req(ifu_req), .ifu_ack(ifu_ack), .ifu_err(ifu_err),
    .ir_we(ir_we), .dec_rd_wr(dec_rd_wr), .dec_is_load(dec_is_load), .dec_is_store(dec_is_store),
    .dec_is_ebreak(dec_is_ebreak), .exe_redirect(exe_redirect), .lsu_req(lsu_req), .lsu_we(lsu_we),
    .lsu_ack(lsu_ack), .lsu_err(lsu_err), .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .commit(commit), .halt(halt), .halt_err(halt_err), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tb_cyc <= rst_n ? tb_cyc + 1 : 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] pv(input longint unsigned v);
`ifdef NPC_SEQ_PERF_EN
    return v;
`else
    return 64'd0 & v;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sig(input bit lsu, input string nm);
    int n = 0;
    while (!(lsu ? lsu_req : ifu_req) && n < 50) begin step(); n++; end
    chk(nm, lsu ? lsu_req : ifu_req, 1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 0;
    repeat (n) begin
      step();
      chk("reset_outputs", {ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_we, pc_sel, commit, halt, halt_err}, 0);
      chk("reset_counters", cycle_cnt | instret_cnt, 0);
    end
    exp_q.delete();
    n_commit = 0;
    ifu_ack = 0; ifu_err = 0; lsu_ack = 0; lsu_err = 0;
    rst_n = 1;
    chk("boot_outputs", {ifu_req, ir_we, lsu_req, lsu_we, rf_we, pc_we, pc_sel, commit, halt, halt_err}, 0);
    step();
    chk("first_ifu_req", ifu_req, 1);
  endtask

  // kind: 0 alu/branch, 1 load, 2 store, 3 ebreak
  task automatic run_instr(input int kind, input int fw, input int mw, input bit redir,
                           input bit rdw, input bit ferr, input bit merr);
    exp_t e;
    bit mem = kind == 1 || kind == 2;
    bit rw = kind == 2 ? 1'b0 : rdw;
    e.herr = ferr || (mem && merr);
    e.is_halt = e.herr || kind == 3;
    e.rf_we = rw;
    e.pc_sel = redir;
    e.lat = 4 + fw + (mem ? 1 + mw : 0);
    e.ret = n_commit;
    if (!e.is_halt) n_commit++;
    exp_q.push_back(e);
    wait_sig(0, "wait_ifu_req");
    dec_rd_wr = rw; dec_is_load = kind == 1; dec_is_store = kind == 2;
    dec_is_ebreak = kind == 3; exe_redirect = redir;
    repeat (fw) begin
      lsu_ack = 1'($urandom); lsu_err = 1'($urandom);
      #1 chk("ifu_req_hold", ifu_req, 1);
      step();
    end
    ifu_ack = 1; ifu_err = ferr; lsu_ack = 0; lsu_err = 0;
    #1 chk("ir_we", ir_we, !ferr);
    step();
    ifu_ack = 0; ifu_err = 0;
    if (ferr || kind == 3 || !mem) return;
    wait_sig(1, "wait_lsu_req");
    repeat (mw) begin
      ifu_ack = 1'($urandom); ifu_err = 1'($urandom);
      chk("lsu_req_hold", lsu_req, 1);
      chk("lsu_we", lsu_we, kind == 2);
      step();
    end
    ifu_ack = 0; ifu_err = 0;
    chk("lsu_we", lsu_we, kind == 2);
    lsu_ack = 1; lsu_err = merr;
    step();
    lsu_ack = 0; lsu_err = 0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_req = 0;
      prev_halt = 0;
    end else begin
      if (ifu_req && !prev_req) f_start = tb_cyc;
      if (commit || (halt && !prev_halt)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: commit=%b halt=%b with nothing expected", commit, halt);
        end else begin
          e = exp_q.pop_front();
          chk("event_is_halt", halt, e.is_halt);
          if (e.is_halt) chk("halt_err", halt_err, e.herr);
          else if (commit) begin
            chk("wb_rf_we", rf_we, e.rf_we);
            chk("wb_pc_we", pc_we, 1);
            chk("wb_pc_sel", pc_sel, e.pc_sel);
            chk("latency", tb_cyc - f_start + 1, e.lat);
            chk("instret_at_commit", instret_cnt, pv(e.ret));
            chk("cycle_cnt", cycle_cnt, pv(tb_cyc));
          end
        end
      end
      prev_req = ifu_req;
      prev_halt = halt;
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    do_reset(3);
    run_instr(0, 0, 0, 0, 1, 0, 0);
    run_instr(1, 0, 3, 0, 1, 0, 0);
    run_instr(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(0, 2), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 1'($urandom), 0, 0);
    run_instr(2, 1, 2, 0, 0, 0, 1);
    repeat (20) begin
      chk("halt_quiet", {ifu_req, lsu_req, rf_we, pc_we, commit}, 0);
      chk("halt_held", halt, 1);
      step();
    end
    chk("queue_drained", exp_q.size(), 0);
    do_reset(2);
    run_instr(0, 1, 0, 0, 1, 0, 0);
    run_instr(3, 0, 0, 0, 0, 0, 0);
    repeat (10) step();
    chk("ebreak_halt", {halt, halt_err}, 2'b10);
    chk("halt_cycle_cnt", cycle_cnt, pv(tb_cyc));
    chk("halt_instret", instret_cnt, pv(1));
    chk("queue_drained", exp_q.size(), 0);
    do_reset(1);
    wait_sig(0, "wait_ifu_req");
    dec_is_load = 1; dec_is_store = 0; dec_is_ebreak = 0;
    ifu_ack = 1;
    step();
    ifu_ack = 0;
    wait_sig(1, "wait_lsu_req");
    step();
    rst_n = 0;
    step();
    chk("mid_reset_drop", {ifu_req, lsu_req, lsu_we, rf_we, pc_we, commit, halt}, 0);
    do_reset(1);
    run_instr(0, 2, 0, 0, 1, 1, 0);
    repeat (3) step();
    chk("fetch_err_halt", {halt, halt_err}, 2'b11);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
